beat_period_meter: RTL and testbench

Measures the interval, in sample ticks, between successive one-cycle beat strobes and reports it as a registered period word with a lock indication. It is the receiving end of the beat strobe that the beat divider produces from the sample-rate enable. Downstream tempo display and the sequencer clock-follow logic consume its `period`/`locked` outputs.

---
 rtl/beat_period_meter_pkg.sv | 21 ++
 rtl/beat_period_meter_period_match.sv | 38 +++
 rtl/dffre.sv | 32 +++
 rtl/beat_period_meter.sv | 177 +++++++++++++++++
 tb/tb_beat_period_meter.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/beat_period_meter_pkg.sv
// -----------------------------------------------------------------------------
// beat_period_meter_pkg
//   Shared synthesis package for the beat divider / beat period meter pair.
//   Holds the FSM state encoding and the tick-counter width default that both
//   ends of the beat strobe agree on.
// -----------------------------------------------------------------------------
package beat_period_meter_pkg;

    // Default width of the tick counter and the reported period word.
    localparam int SIGNAL_WIDTH_DEFAULT = 16;

    // Width of the consecutive-match counter; LOCK_COUNT must fit in it.
    localparam int MATCH_CNT_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,  // first beat not yet seen
        ST_MEASURE = 2'd1,  // counting ticks since the last beat
        ST_OVERRUN = 2'd2   // tick counter saturated, waiting for a beat
    } state_e;

endpackage

// File: rtl/beat_period_meter_period_match.sv
// -----------------------------------------------------------------------------
// period_match
//   Combinational compare of a fresh measurement against the previous one.
//   match is high when |value - prev| <= TOLERANCE.
//   Ports:
//     value - newly measured interval in ticks
//     prev  - previously measured interval in ticks
//     match - the two intervals agree within TOLERANCE
// -----------------------------------------------------------------------------
module period_match #(
    parameter int SIGNAL_WIDTH = 16,
    parameter int TOLERANCE    = 2
) (
    input  logic [SIGNAL_WIDTH-1:0] value,
    input  logic [SIGNAL_WIDTH-1:0] prev,
    output logic                    match
);

    localparam logic [SIGNAL_WIDTH:0] TOL_W = (SIGNAL_WIDTH + 1)'(TOLERANCE);

    logic [SIGNAL_WIDTH:0] value_w;
    logic [SIGNAL_WIDTH:0] prev_w;
    logic [SIGNAL_WIDTH:0] diff;

    // One extra bit and an ordered subtraction: the difference can never wrap.
    always_comb begin
        value_w = {1'b0, value};
        prev_w  = {1'b0, prev};
        if (value_w >= prev_w) begin
            diff = value_w - prev_w;
        end else begin
            diff = prev_w - value_w;
        end
    end

    assign match = (diff <= TOL_W);

endmodule

// File: rtl/dffre.sv
// -----------------------------------------------------------------------------
// dffre
//   Generic D flop bank with synchronous active-high reset and load enable.
//   Ports:
//     clk   - clock
//     reset - synchronous, active-high; loads RESET_VAL
//     en    - load enable; q holds when low
//     d     - next value
//     q     - registered value
// -----------------------------------------------------------------------------
module dffre #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // NOTE: sequential state is always written with non-blocking assignments
    // so every flop samples the pre-edge values of its inputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= RESET_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/beat_period_meter.sv
// -----------------------------------------------------------------------------
// beat_period_meter
//   Measures the number of sample ticks between successive beat strobes and
//   reports it as a registered period word with a lock indication.
//   Ports:
//     clk          - system clock, single domain
//     reset        - synchronous, active-high
//     tick         - sample-rate enable, one cycle per sample
//     beat         - beat strobe, one cycle wide
//     period       - last measured beat interval in ticks
//     period_valid - one-cycle pulse when period updates
//     locked       - LOCK_COUNT consecutive matching intervals seen
//     overrun      - interval exceeded counter range; held until next beat
// -----------------------------------------------------------------------------
module beat_period_meter
    import beat_period_meter_pkg::*;
#(
    parameter int SIGNAL_WIDTH = SIGNAL_WIDTH_DEFAULT,
    parameter int LOCK_COUNT   = 4,
    parameter int TOLERANCE    = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    tick,
    input  logic                    beat,
    output logic [SIGNAL_WIDTH-1:0] period,
    output logic                    period_valid,
    output logic                    locked,
    output logic                    overrun
);

    localparam logic [SIGNAL_WIDTH-1:0]    CNT_MAX  = '1;
    localparam logic [SIGNAL_WIDTH-1:0]    CNT_ONE  = SIGNAL_WIDTH'(1);
    localparam logic [MATCH_CNT_WIDTH-1:0] LOCK_MAX = MATCH_CNT_WIDTH'(LOCK_COUNT);

    // ------------------------------------------------------------------ state
    state_e                      state_q, state_d;
    logic [1:0]                  state_raw_q;
    logic [SIGNAL_WIDTH-1:0]     cnt_q, cnt_d;
    logic [SIGNAL_WIDTH-1:0]     prev_q;
    logic [SIGNAL_WIDTH-1:0]     period_q;
    logic [MATCH_CNT_WIDTH-1:0]  match_cnt_q, match_cnt_d;
    logic                        first_q, first_d;
    logic                        overrun_q, overrun_d;
    logic                        period_valid_q, period_valid_d;

    // -------------------------------------------------------------- datapath
    logic                    meas_fire;   // beat closing an interval in MEASURE
    logic [SIGNAL_WIDTH-1:0] meas_value;  // cnt + tick, saturating at CNT_MAX
    logic                    match;

    assign state_q   = state_e'(state_raw_q);
    assign meas_fire = (state_q == ST_MEASURE) && beat;

    // A tick in the beat cycle belongs to the interval being closed; at full
    // count it saturates instead of signalling overrun.
    assign meas_value = (tick && (cnt_q != CNT_MAX)) ? (cnt_q + CNT_ONE) : cnt_q;

    period_match #(
        .SIGNAL_WIDTH (SIGNAL_WIDTH),
        .TOLERANCE    (TOLERANCE)
    ) u_period_match (
        .value (meas_value),
        .prev  (prev_q),
        .match (match)
    );

    // ------------------------------------------------------ state register
    dffre #(.WIDTH(2), .RESET_VAL(ST_IDLE)) u_state_ff (
        .clk (clk), .reset (reset), .en (1'b1), .d (state_d), .q (state_raw_q)
    );

    // ---------------------------------------------------------- next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (beat) state_d = ST_MEASURE;
            end
            ST_MEASURE: begin
                if (tick && !beat && (cnt_q == CNT_MAX)) state_d = ST_OVERRUN;
            end
            ST_OVERRUN: begin
                if (beat) state_d = ST_MEASURE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // -------------------------------------------------------------- outputs
    // NOTE: every variable assigned below gets a default first, so no path
    // through the case leaves one unassigned and no latch is inferred.
    always_comb begin
        cnt_d          = cnt_q;
        first_d        = first_q;
        overrun_d      = overrun_q;
        match_cnt_d    = match_cnt_q;
        period_valid_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (beat) begin
                    cnt_d   = '0;
                    first_d = 1'b1;
                end
            end
            ST_MEASURE: begin
                if (beat) begin
                    cnt_d          = '0;
                    period_valid_d = 1'b1;
                    if (first_q) begin
                        // Nothing to compare against yet; only seed prev.
                        first_d = 1'b0;
                    end else if (match) begin
                        if (match_cnt_q < LOCK_MAX) begin
                            match_cnt_d = match_cnt_q + 1'b1;
                        end
                    end else begin
                        match_cnt_d = '0;
                    end
                end else if (tick) begin
                    if (cnt_q == CNT_MAX) begin
                        // Hold cnt, flag overrun and drop any lock.
                        overrun_d   = 1'b1;
                        match_cnt_d = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end
            ST_OVERRUN: begin
                if (beat) begin
                    cnt_d     = '0;
                    overrun_d = 1'b0;
                    first_d   = 1'b1;
                end
            end
            default: begin
                cnt_d = '0;
            end
        endcase
    end

    // ---------------------------------------------------------------- flops
    dffre #(.WIDTH(SIGNAL_WIDTH)) u_cnt_ff (
        .clk (clk), .reset (reset), .en (1'b1), .d (cnt_d), .q (cnt_q)
    );

    dffre #(.WIDTH(SIGNAL_WIDTH)) u_prev_ff (
        .clk (clk), .reset (reset), .en (meas_fire), .d (meas_value), .q (prev_q)
    );

    dffre #(.WIDTH(SIGNAL_WIDTH)) u_period_ff (
        .clk (clk), .reset (reset), .en (meas_fire), .d (meas_value), .q (period_q)
    );

    dffre #(.WIDTH(MATCH_CNT_WIDTH)) u_match_cnt_ff (
        .clk (clk), .reset (reset), .en (1'b1), .d (match_cnt_d), .q (match_cnt_q)
    );

    dffre #(.WIDTH(1), .RESET_VAL(1'b1)) u_first_ff (
        .clk (clk), .reset (reset), .en (1'b1), .d (first_d), .q (first_q)
    );

    dffre #(.WIDTH(1)) u_overrun_ff (
        .clk (clk), .reset (reset), .en (1'b1), .d (overrun_d), .q (overrun_q)
    );

    dffre #(.WIDTH(1)) u_period_valid_ff (
        .clk (clk), .reset (reset), .en (1'b1), .d (period_valid_d), .q (period_valid_q)
    );

    assign period       = period_q;
    assign period_valid = period_valid_q;
    assign locked       = (match_cnt_q == LOCK_MAX);
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_beat_period_meter.sv
// -----------------------------------------------------------------------------
// tb_beat_period_meter
//   Drives a 16-bit and an 8-bit beat_period_meter from shared tick/beat/reset.
//   The 16-bit instance is checked on every beat against a reference model that
//   keeps the history of measured intervals and derives lock from it; the 8-bit
//   instance covers overrun and saturation with directed expectations.
// -----------------------------------------------------------------------------
module tb_beat_period_meter;

    localparam int LOCK_COUNT = 4;
    localparam int TOLERANCE  = 2;
    localparam int MAX16      = 65535;

    logic        clk;
    logic        reset;
    logic        tick;
    logic        beat;

    logic [15:0] period16;
    logic        pv16, locked16, ov16;
    logic [7:0]  period8;
    logic        pv8, locked8, ov8;

    int tests_run;
    int tests_failed;

    // Reference model state for the 16-bit instance.
    bit m_armed;     // a beat has been seen since reset
    int m_ticks;     // ticks counted since the last beat
    int m_hist[$];   // recent measured intervals, oldest first
    bit prev_beat;

    beat_period_meter #(
        .SIGNAL_WIDTH (16), .LOCK_COUNT (LOCK_COUNT), .TOLERANCE (TOLERANCE)
    ) dut16 (
        .clk (clk), .reset (reset), .tick (tick), .beat (beat),
        .period (period16), .period_valid (pv16), .locked (locked16), .overrun (ov16)
    );

    beat_period_meter #(
        .SIGNAL_WIDTH (8), .LOCK_COUNT (LOCK_COUNT), .TOLERANCE (TOLERANCE)
    ) dut8 (
        .clk (clk), .reset (reset), .tick (tick), .beat (beat),
        .period (period8), .period_valid (pv8), .locked (locked8), .overrun (ov8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Locked when the last LOCK_COUNT consecutive pairs of intervals all agree.
    function automatic bit model_locked();
        int run;
        run = 0;
        for (int i = m_hist.size() - 1; i >= 1; i--) begin
            int d;
            d = m_hist[i] - m_hist[i-1];
            if (d < 0) d = -d;
            if (d <= TOLERANCE) run++;
            else break;
        end
        return run >= LOCK_COUNT;
    endfunction

    // One clock cycle with the given inputs; the model tracks the 16-bit DUT.
    task automatic cycle(input logic b, input logic t);
        int  val;
        bit  exp_valid;
        beat = b;
        tick = t;
        @(posedge clk);
        #1;
        exp_valid = 1'b0;
        val       = 0;
        if (b) begin
            if (m_armed) begin
                val = m_ticks + int'(t);
                if (val > MAX16) val = MAX16;
                exp_valid = 1'b1;
                m_hist.push_back(val);
                if (m_hist.size() > LOCK_COUNT + 1) void'(m_hist.pop_front());
            end
            m_armed = 1'b1;
            m_ticks = 0;
            check("valid16", 32'(pv16), 32'(exp_valid));
            if (exp_valid) check("period16", 32'(period16), val);
            check("locked16", 32'(locked16), 32'(model_locked()));
        end else begin
            if (m_armed && t) m_ticks++;
            if (prev_beat) check("valid16_clear", 32'(pv16), 0);
        end
        prev_beat = b;
        beat = 1'b0;
        tick = 1'b0;
    endtask

    // n_before tick cycles, then a beat cycle with the given tick.
    task automatic interval(input int n_before, input logic tick_on_beat);
        for (int i = 0; i < n_before; i++) cycle(1'b0, 1'b1);
        cycle(1'b1, tick_on_beat);
    endtask

    // Reset with beat and tick also high: reset must win.
    task automatic do_reset();
        reset = 1'b1;
        beat  = 1'b1;
        tick  = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        beat  = 1'b0;
        tick  = 1'b0;
        check("rst_period16", 32'(period16), 0);
        check("rst_valid16",  32'(pv16), 0);
        check("rst_locked16", 32'(locked16), 0);
        check("rst_overrun16", 32'(ov16), 0);
        check("rst_period8",  32'(period8), 0);
        check("rst_locked8",  32'(locked8), 0);
        check("rst_overrun8", 32'(ov8), 0);
        m_armed   = 1'b0;
        m_ticks   = 0;
        m_hist.delete();
        prev_beat = 1'b0;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset = 1'b1;
        tick  = 1'b0;
        beat  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Continuous tick, beat every 4800 cycles.
        cycle(1'b1, 1'b1);   // first beat arms, no period_valid
        interval(4799, 1'b1);
        check("p4800_first", 32'(period16), 4800);
        check("p4800_first_unlocked", 32'(locked16), 0);
        for (int i = 0; i < 3; i++) interval(4799, 1'b1);
        check("p4800_4th_unlocked", 32'(locked16), 0);
        interval(4799, 1'b1);
        check("p4800_5th_locked", 32'(locked16), 1);

        // Tempo change to 4803: lock drops at once, regained after four matches.
        interval(4802, 1'b1);
        check("p4803_period", 32'(period16), 4803);
        check("p4803_unlock", 32'(locked16), 0);
        for (int i = 0; i < 3; i++) begin
            interval(4802, 1'b1);
            check("p4803_not_yet", 32'(locked16), 0);
        end
        interval(4802, 1'b1);
        check("p4803_relock", 32'(locked16), 1);

        // Alternating 100/102 stays within tolerance.
        for (int i = 0; i < 3; i++) begin
            interval(99, 1'b1);
            interval(101, 1'b1);
        end
        check("alt102_locked", 32'(locked16), 1);

        // Alternating 100/103 never locks.
        do_reset();
        cycle(1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            interval(99, 1'b1);
            check("alt103_unlocked_a", 32'(locked16), 0);
            interval(102, 1'b1);
            check("alt103_unlocked_b", 32'(locked16), 0);
        end

        // Beat coincident with a tick after 9 ticks, then a zero-length interval.
        interval(9, 1'b1);
        check("coincident_period", 32'(period16), 10);
        cycle(1'b1, 1'b0);
        check("zero_period", 32'(period16), 0);
        check("zero_valid", 32'(pv16), 1);

        // Randomized intervals: steady-ish tempo or sparse random ticks.
        for (int k = 0; k < 40; k++) begin
            int n;
            if ($urandom_range(1, 0) == 1) begin
                n = 30 + int'($urandom_range(3, 0));
                for (int i = 0; i < n; i++) cycle(1'b0, 1'b1);
            end else begin
                n = int'($urandom_range(40, 0));
                for (int i = 0; i < n; i++) cycle(1'b0, logic'($urandom_range(1, 0)));
            end
            cycle(1'b1, logic'($urandom_range(1, 0)));
        end

        // Reset mid-interval while locked.
        for (int i = 0; i < 6; i++) interval(49, 1'b1);
        check("pre_reset_locked", 32'(locked16), 1);
        for (int i = 0; i < 20; i++) cycle(1'b0, 1'b1);
        do_reset();
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1);
        cycle(1'b1, 1'b1);
        check("post_reset_no_valid", 32'(pv16), 0);

        // 8-bit instance: lock, overrun, recovery and saturation.
        do_reset();
        cycle(1'b1, 1'b1);
        for (int i = 0; i < 5; i++) interval(19, 1'b1);
        check("w8_period20", 32'(period8), 20);
        check("w8_locked", 32'(locked8), 1);
        for (int i = 0; i < 255; i++) cycle(1'b0, 1'b1);
        check("w8_no_overrun_at_max", 32'(ov8), 0);
        cycle(1'b0, 1'b1);
        check("w8_overrun", 32'(ov8), 1);
        check("w8_overrun_unlocked", 32'(locked8), 0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1);
        check("w8_overrun_held", 32'(ov8), 1);
        cycle(1'b1, 1'b1);
        check("w8_recover_no_valid", 32'(pv8), 0);
        check("w8_recover_overrun_clear", 32'(ov8), 0);
        interval(10, 1'b0);
        check("w8_period10", 32'(period8), 10);
        check("w8_period10_valid", 32'(pv8), 1);
        interval(255, 1'b1);
        check("w8_saturate_period", 32'(period8), 255);
        check("w8_saturate_valid", 32'(pv8), 1);
        check("w8_saturate_no_overrun", 32'(ov8), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
